// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the dodge game controller
// Purpose: game state encoding, start keycode and BCD digit limit.
// Ports:   none (package).
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [3:0] BCD_MAX   = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decade of the BCD score counter
// Purpose: 4-bit BCD counter that wraps 9->0 and ripples a carry to the next decade.
// Ports:   MAX10_CLK1_50 clock, Reset_h async active-high reset,
//          inc_in increment request, clr synchronous clear, sat blocks any change,
//          digit current value, carry_out = increment request while at 9.
module bcd_digit
  import game_pkg::*;
(
  input  logic       MAX10_CLK1_50,
  input  logic       Reset_h,
  input  logic       inc_in,
  input  logic       clr,
  input  logic       sat,
  output logic [3:0] digit,
  output logic       carry_out
);

  // Carry depends only on the request and the stored value, never on sat,
  // so the top can derive sat from the end of the chain without a loop.
  assign carry_out = inc_in && (digit == BCD_MAX);

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (inc_in && !sat) begin
      digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/survival_timer.sv
// rtl/survival_timer.sv - game-state controller and score keeper for the dodge game
// Purpose: runs the IDLE/RUN/OVER game FSM, counts survival time as a six-digit BCD
//          score, keeps the session high score and gates ball motion via run.
// Ports:   MAX10_CLK1_50 50 MHz clock, Reset_h async active-high reset,
//          collide level from ball (other clock domain), keycode USB keycode,
//          run high in RUN, game_state FSM state, hex_digits six BCD nibbles
//          (units in [3:0]), new_record score beat the previous high score,
//          led elapsed ticks mod 1024.
module survival_timer
  import game_pkg::*;
#(
  parameter int         TICK_DIV  = 50_000_000,
  parameter logic [7:0] START_KEY = KEY_SPACE,
  parameter int         SYNC_STG  = 2
) (
  input  logic        MAX10_CLK1_50,
  input  logic        Reset_h,
  input  logic        collide,
  input  logic [7:0]  keycode,
  output logic        run,
  output logic [1:0]  game_state,
  output logic [23:0] hex_digits,
  output logic        new_record,
  output logic [9:0]  led
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t              state;
  logic [SYNC_STG-1:0] sync_q;
  logic                col_s;
  logic [7:0]          key_prev;
  logic                start;
  logic [PW-1:0]       presc;
  logic                tick;
  logic                entry;
  logic                score_inc;
  logic [23:0]         score;
  logic [23:0]         hi;
  logic [6:0]          carry;

  assign game_state = state;

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], collide};
    end
  end
  assign col_s = sync_q[SYNC_STG-1];

  // A held key yields a single pulse: only the transition onto START_KEY counts.
  assign start = (keycode == START_KEY) && (key_prev != START_KEY);

  assign tick      = (state == RUN) && (presc == PRESC_LAST);
  // A collision in the tick cycle wins, so the score never advances then.
  assign score_inc = tick && !col_s;
  assign entry     = (state != RUN) && start && !col_s;

  // carry[6] is high only when every decade is 9 and an increment is requested,
  // which is exactly the saturation point at 999999.
  assign carry[0] = score_inc;
  for (genvar i = 0; i < 6; i++) begin : g_digit
    bcd_digit u_digit (
      .MAX10_CLK1_50 (MAX10_CLK1_50),
      .Reset_h       (Reset_h),
      .inc_in        (carry[i]),
      .clr           (entry),
      .sat           (carry[6]),
      .digit         (score[4*i +: 4]),
      .carry_out     (carry[i+1])
    );
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      state      <= IDLE;
      run        <= 1'b0;
      presc      <= '0;
      hi         <= '0;
      new_record <= 1'b0;
      led        <= '0;
      key_prev   <= '0;
      hex_digits <= '0;
    end else begin
      key_prev   <= keycode;
      hex_digits <= (state == IDLE) ? hi : score;
      case (state)
        IDLE, OVER: begin
          presc <= '0;
          if (entry) begin
            state      <= RUN;
            run        <= 1'b1;
            led        <= '0;
            new_record <= 1'b0;
          end
        end
        RUN: begin
          presc <= tick ? '0 : presc + 1'b1;
          if (col_s) begin
            state <= OVER;
            run   <= 1'b0;
            // BCD digits compare in numeric order, so a plain magnitude test works.
            if (score > hi) begin
              hi         <= score;
              new_record <= 1'b1;
            end
          end else if (tick) begin
            led <= led + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          run   <= 1'b0;
          presc <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_survival_timer.sv
// tb/tb_survival_timer.sv - self-checking bench for survival_timer
module tb_survival_timer;

  localparam int TD = 4;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        collide;
  logic [7:0]  keycode;
  logic        run;
  logic [1:0]  gs;
  logic [23:0] hex;
  logic        nr;
  logic [9:0]  led;

  always #5 clk = ~clk;

  survival_timer #(.TICK_DIV(TD), .START_KEY(8'h2C), .SYNC_STG(SS)) dut (
    .MAX10_CLK1_50 (clk),
    .Reset_h       (rst),
    .collide       (collide),
    .keycode       (keycode),
    .run           (run),
    .game_state    (gs),
    .hex_digits    (hex),
    .new_record    (nr),
    .led           (led)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: score and high score held as plain integers.
  int m_state, m_score, m_hi, m_led, m_nr, m_presc, m_hex, m_kprev;
  int m_hist[SS];

  typedef struct {
    logic [7:0]  key;
    logic        col;
    int          n;
    logic [1:0]  st;
    logic [23:0] hx;
    logic [9:0]  ld;
    logic        nr;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_hi = 0; m_led = 0; m_nr = 0;
    m_presc = 0; m_hex = 0; m_kprev = 0;
    for (int i = 0; i < SS; i++) m_hist[i] = 0;
  endtask

  task automatic model_step();
    int  col_s;
    bit  start, tick, entry;
    col_s = m_hist[SS-1];
    start = (keycode == 8'h2C) && (m_kprev != 8'h2C);
    tick  = (m_state == 1) && (m_presc == TD - 1);
    entry = start && (col_s == 0) && (m_state != 1);
    m_hex = (m_state == 0) ? m_hi : m_score;
    if (m_state == 1) begin
      m_presc = (m_presc + 1) % TD;
      if (col_s != 0) begin
        m_state = 2;
        if (m_score > m_hi) begin
          m_hi = m_score;
          m_nr = 1;
        end
      end else if (tick) begin
        if (m_score < 999999) m_score++;
        m_led = (m_led + 1) % 1024;
      end
    end else begin
      m_presc = 0;
      if (entry) begin
        m_state = 1; m_score = 0; m_led = 0; m_nr = 0;
      end
    end
    for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = int'(collide);
    m_kprev   = int'(keycode);
  endtask

  task automatic check_model();
    chk("m_state", 32'(gs), 32'(m_state));
    chk("m_run", 32'(run), (m_state == 1) ? 32'd1 : 32'd0);
    chk("m_hex", 32'(hex), 32'(to_bcd(m_hex)));
    chk("m_led", 32'(led), 32'(m_led));
    chk("m_new_record", 32'(nr), 32'(m_nr));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic press_start();
    keycode = 8'h2C;
    step();
    keycode = 8'h00;
  endtask

  // Play one game, colliding exactly on the tick that would make score n+1.
  task automatic game_to(input int n, input logic exp_nr);
    collide = 1'b0;
    keycode = 8'h00;
    repeat (3) step();
    press_start();
    repeat (4*n + 1) step();
    collide = 1'b1;
    repeat (3) step();
    chk("go_state", 32'(gs), 32'd2);
    chk("go_hex", 32'(hex), 32'(to_bcd(n)));
    chk("go_led", 32'(led), 32'(n));
    chk("go_new_record", 32'(nr), 32'(exp_nr));
    step();
    chk("go_hex_hold", 32'(hex), 32'(to_bcd(n)));
  endtask

  task automatic force_nines(input int k);
    if (k > 0) force dut.g_digit[0].u_digit.digit = 4'd9;
    if (k > 1) force dut.g_digit[1].u_digit.digit = 4'd9;
    if (k > 2) force dut.g_digit[2].u_digit.digit = 4'd9;
    if (k > 3) force dut.g_digit[3].u_digit.digit = 4'd9;
    if (k > 4) force dut.g_digit[4].u_digit.digit = 4'd9;
    if (k > 5) force dut.g_digit[5].u_digit.digit = 4'd9;
    #1;
    release dut.g_digit[0].u_digit.digit;
    release dut.g_digit[1].u_digit.digit;
    release dut.g_digit[2].u_digit.digit;
    release dut.g_digit[3].u_digit.digit;
    release dut.g_digit[4].u_digit.digit;
    release dut.g_digit[5].u_digit.digit;
  endtask

  initial begin
    tbl[0] = '{8'h00, 1'b0,  2, 2'd0, 24'h000000, 10'd0, 1'b0};
    tbl[1] = '{8'h2C, 1'b0,  1, 2'd1, 24'h000000, 10'd0, 1'b0};
    tbl[2] = '{8'h2C, 1'b0, 13, 2'd1, 24'h000003, 10'd3, 1'b0};
    tbl[3] = '{8'h2C, 1'b0,  6, 2'd1, 24'h000004, 10'd4, 1'b0};
    tbl[4] = '{8'h00, 1'b0,  1, 2'd1, 24'h000004, 10'd5, 1'b0};
    tbl[5] = '{8'h00, 1'b1,  3, 2'd2, 24'h000005, 10'd5, 1'b1};
    tbl[6] = '{8'h00, 1'b0,  3, 2'd2, 24'h000005, 10'd5, 1'b1};

    rst = 1'b1;
    collide = 1'b0;
    keycode = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(gs), 32'd0);
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_hex", 32'(hex), 32'h000000);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_new_record", 32'(nr), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      keycode = tbl[i].key;
      collide = tbl[i].col;
      repeat (tbl[i].n) step();
      chk($sformatf("tbl%0d_state", i), 32'(gs), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_run", i), 32'(run), (tbl[i].st == 2'd1) ? 32'd1 : 32'd0);
      chk($sformatf("tbl%0d_hex", i), 32'(hex), 32'(tbl[i].hx));
      chk($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].ld));
      chk($sformatf("tbl%0d_new_record", i), 32'(nr), 32'(tbl[i].nr));
    end

    game_to(7, 1'b1);
    game_to(5, 1'b0);
    game_to(7, 1'b0);
    game_to(8, 1'b1);

    collide = 1'b0;
    keycode = 8'h00;
    repeat (3) step();
    press_start();
    step();
    force_nines(2);
    m_score = 99;
    repeat (4) step();
    chk("carry_hex", 32'(hex), 32'h000100);
    chk("carry_led", 32'(led), 32'd1);
    force_nines(6);
    m_score = 999999;
    repeat (4) step();
    chk("sat_hex", 32'(hex), 32'h999999);
    chk("sat_led", 32'(led), 32'd2);
    repeat (4) step();
    chk("sat_hex2", 32'(hex), 32'h999999);
    chk("sat_led2", 32'(led), 32'd3);

    repeat (3) step();
    press_start();
    repeat (6) step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(gs), 32'd0);
    chk("arst_run", 32'(run), 32'd0);
    chk("arst_hex", 32'(hex), 32'h000000);
    chk("arst_led", 32'(led), 32'd0);
    chk("arst_new_record", 32'(nr), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    collide = 1'b1;
    repeat (3) step();
    keycode = 8'h2C;
    step();
    chk("blocked_state", 32'(gs), 32'd0);
    collide = 1'b0;
    repeat (4) step();
    chk("held_state", 32'(gs), 32'd0);
    chk("hi_cleared_hex", 32'(hex), 32'h000000);
    keycode = 8'h00;
    step();

    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2) keycode = 8'h2C;
      else if (r == 2) keycode = 8'($urandom);
      else keycode = 8'h00;
      if ($urandom_range(0, 39) == 0) collide = ~collide;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
